// File: rtl/request_unit.sv
// Memory request sequencer between the control unit and instruction/data memories.
// Issues data requests after an accepted fetch, strobes PC advance, latches halt, counts data stalls.
module request_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        cu_iren,
  input  logic        cu_dren,
  input  logic        cu_dwen,
  input  logic        cu_halt,
  input  logic        ihit,
  input  logic        dhit,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, HALTED} state_t;

  state_t      state, next_state;
  logic        next_ren, next_wen, next_halt;
  logic [15:0] next_stall;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      halt      <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      state     <= next_state;
      dmemREN   <= next_ren;
      dmemWEN   <= next_wen;
      halt      <= next_halt;
      stall_cnt <= next_stall;
    end
  end

  always_comb begin
    next_state = state;
    next_ren   = dmemREN;
    next_wen   = dmemWEN;
    next_halt  = halt;
    next_stall = stall_cnt;
    case (state)
      IDLE: begin
        // Halt decode takes priority over any data request of the same instruction.
        if (ihit) begin
          if (cu_halt) begin
            next_state = HALTED;
            next_halt  = 1'b1;
          end else if (cu_dren || cu_dwen) begin
            next_state = DATA;
            next_ren   = cu_dren & ~cu_dwen;
            next_wen   = cu_dwen;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          next_state = IDLE;
          next_ren   = 1'b0;
          next_wen   = 1'b0;
        end else begin
          next_stall = sat_inc(stall_cnt);
        end
      end
      HALTED: begin
        next_ren  = 1'b0;
        next_wen  = 1'b0;
        next_halt = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    // Gated by nRST so no advance strobe leaks out while reset is held.
    pc_en = nRST & (((state == IDLE) & ihit & ~cu_halt & ~cu_dren & ~cu_dwen) |
                    ((state == DATA) & dhit));
    imemREN = cu_iren & (state != HALTED);
  end

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: directed scenarios, stall saturation, then random traffic.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        cu_iren, cu_dren, cu_dwen, cu_halt, ihit, dhit;
  logic        imemREN, dmemREN, dmemWEN, pc_en, halt;
  logic [15:0] stall_cnt;

  request_unit dut (
    .CLK(CLK), .nRST(nRST),
    .cu_iren(cu_iren), .cu_dren(cu_dren), .cu_dwen(cu_dwen), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pc_en(pc_en), .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Expected outputs per cycle: {imemREN, dmemREN, dmemWEN, pc_en, halt, stall_cnt}
  logic [20:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: instruction in flight (none / load / store) or halted, plus stall total.
  bit m_halted;
  bit m_busy;
  bit m_is_store;
  int m_stalls;

  task automatic model_reset();
    m_halted = 0; m_busy = 0; m_is_store = 0; m_stalls = 0;
  endtask

  task automatic step(input bit iren, input bit dren, input bit dwen, input bit hlt,
                      input bit ih, input bit dh, input bit rstn);
    bit exp_pc, exp_imem;
    cu_iren = iren; cu_dren = dren; cu_dwen = dwen; cu_halt = hlt;
    ihit = ih; dhit = dh; nRST = rstn;
    if (!rstn) model_reset();
    exp_pc = rstn && !m_halted &&
             ((!m_busy && ih && !hlt && !dren && !dwen) || (m_busy && dh));
    exp_imem = iren && !m_halted;
    exp_q.push_back({exp_imem, m_busy && !m_is_store, m_busy && m_is_store,
                     exp_pc, m_halted, m_stalls[15:0]});
    @(posedge CLK);
    if (rstn && !m_halted) begin
      if (m_busy) begin
        if (dh) m_busy = 0;
        else if (m_stalls < 65535) m_stalls = m_stalls + 1;
      end else if (ih) begin
        if (hlt) m_halted = 1;
        else if (dren || dwen) begin
          m_busy = 1;
          m_is_store = dwen;
        end
      end
    end
    #1;
  endtask

  initial begin : monitor
    logic [20:0] got, exp;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {imemREN, dmemREN, dmemWEN, pc_en, halt, stall_cnt};
        checks++;
        if (got === exp) passed++;
        else $display("FAIL outputs t=%0t {imemREN,dmemREN,dmemWEN,pc_en,halt}=%b stall_cnt=%h, expected %b stall_cnt=%h",
                      $time, got[20:16], got[15:0], exp[20:16], exp[15:0]);
      end
    end
  end

  initial begin
    cu_iren = 0; cu_dren = 0; cu_dwen = 0; cu_halt = 0; ihit = 0; dhit = 0; nRST = 0;
    model_reset();
    @(posedge CLK); #1;

    // Reset state, with fetch activity that must not produce pc_en
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 1, 1);
    // ALU op
    step(1, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    // Load with 3-cycle memory
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    // Store with both dren and dwen, then ihit+dhit together in DATA
    step(1, 1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    // Halt with a write in the same instruction; later hits ignored
    step(1, 0, 1, 1, 1, 0, 1);
    step(1, 0, 0, 0, 1, 1, 1);
    step(1, 1, 1, 0, 1, 0, 1);
    step(1, 0, 0, 0, 1, 1, 1);
    // Reset out of HALTED, then reset in the middle of a load
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    // Stall counter saturation
    step(1, 0, 1, 0, 1, 0, 1);
    for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 1'($urandom_range(0, 1)), 0, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    // Random traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 49) != 0));

    @(negedge CLK); #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain queue_left=%0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-low, on ports CLK and nRST.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- cu_iren  in  1  control-unit instruction-read request.
- cu_dren  in  1  control-unit data-read request for the current instruction.
- cu_dwen  in  1  control-unit data-write request for the current instruction.
- cu_halt  in  1  control-unit halt decode.
- ihit  in  1  instruction-memory access complete this cycle.
- dhit  in  1  data-memory access complete this cycle.
- imemREN  out  1  instruction fetch request to memory.
- dmemREN  out  1  data read request to memory, registered.
- dmemWEN  out  1  data write request to memory, registered.
- pc_en  out  1  PC advance strobe, combinational.
- halt  out  1  sticky processor halt, registered.
- stall_cnt  out  16  count of data-wait cycles, saturating.
REQ-003 SHALL define no parameters.

Function
REQ-004 SHALL implement an FSM with states IDLE, DATA and HALTED; the reset state is IDLE.
REQ-005 In IDLE, when ihit=1 and cu_halt=1, SHALL go to HALTED and set halt=1 on the next edge; cu_dren and cu_dwen are ignored in that cycle.
REQ-006 In IDLE, when ihit=1, cu_halt=0 and (cu_dren or cu_dwen)=1, SHALL go to DATA and register dmemREN<=cu_dren&~cu_dwen and dmemWEN<=cu_dwen.
REQ-007 When cu_dren and cu_dwen are both 1, the write SHALL win: dmemWEN=1 and dmemREN=0.
REQ-008 In IDLE with ihit=0, SHALL stay in IDLE with no output change; dhit in IDLE is ignored.
REQ-009 In DATA, dmemREN and dmemWEN SHALL hold stable until dhit=1.
REQ-010 In DATA with dhit=1, SHALL clear dmemREN and dmemWEN on the next edge and return to IDLE.
REQ-011 In DATA, ihit SHALL be ignored, including when ihit and dhit are asserted in the same cycle.
REQ-012 pc_en SHALL be the OR of two terms:
- (state==IDLE & ihit & ~cu_halt & ~cu_dren & ~cu_dwen)
- (state==DATA & dhit).
REQ-013 pc_en SHALL never be 1 in HALTED or during reset.
REQ-014 imemREN SHALL equal cu_iren & (state!=HALTED); it is 1 from reset onward while cu_iren=1.
REQ-015 HALTED SHALL be absorbing until nRST; in it halt=1, dmemREN=0, dmemWEN=0, imemREN=0 and pc_en=0.
REQ-016 stall_cnt SHALL increment by 1 on each edge where state==DATA and dhit=0.
REQ-017 stall_cnt SHALL saturate at 16'hFFFF with no wrap, and is never cleared except by reset.
REQ-018 Latency: request asserted 1 cycle after the accepting ihit; released 1 cycle after dhit; a single-cycle dhit gives a 2-cycle data instruction.

Reset
REQ-019 On nRST=0, regardless of clock, SHALL set state=IDLE, dmemREN=0, dmemWEN=0, halt=0 and stall_cnt=0.
REQ-020 Reset asserted in DATA SHALL abort the outstanding data request immediately, with no wait for dhit.
REQ-021 Reset asserted in HALTED SHALL clear halt, and operation SHALL resume in IDLE on the first edge after nRST rises.

Verification
REQ-022 Bench SHALL cover these scenarios:
- ALU op: cu_iren=1, ihit=1, cu_dren=cu_dwen=0 -> pc_en=1 that cycle; dmemREN=dmemWEN=0; state stays IDLE.
- Load, 3-cycle memory: ihit=1 with cu_dren=1 -> dmemREN=1 next cycle; dhit on the 3rd DATA cycle -> pc_en=1 that cycle, dmemREN=0 next edge, stall_cnt=2.
- Store with both dren and dwen set: ihit=1 with cu_dren=cu_dwen=1 -> dmemWEN=1, dmemREN=0; ihit=dhit=1 in DATA -> single pc_en pulse, return to IDLE.
- Halt: ihit=1 with cu_halt=1 and cu_dwen=1 -> halt=1 next edge; dmemWEN stays 0; imemREN=0; later ihit/dhit give pc_en=0.
- Reset mid-access: nRST=0 in DATA mid-clock -> dmemREN=0 asynchronously and stall_cnt=0; after release, state=IDLE and imemREN=cu_iren.
- Saturation: hold DATA with dhit=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.
